rr_arbiter32: RTL and testbench

- Round-robin arbiter that shares one 32-lane resource slot among 32 requesters.
- Produces a registered one-hot grant, plus the matching 5-bit binary index, so downstream logic does not need a separate encode stage.
- Sits in front of the max16 datapath to sequence which source lane owns the shared compare/encode path each transaction.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/rr_pick32.sv | 26 ++
 rtl/rr_arbiter32.sv | 103 ++++++++++
 tb/tb_rr_arbiter32.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter types: requester count, index width, FSM states, one-hot encoder.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package arb_pkg;

    localparam int NREQ  = 32;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Encodes a one-hot (or zero) vector to its bit index; zero encodes to 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick32.sv
// Round-robin winner pick: first set req bit at or above ptr, wrapping 31->0.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick32
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [NREQ-1:0]  win_onehot,
    output logic [IDX_W-1:0] win_idx
);

    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] sel;

    // Prefer requesters at or above ptr; fall back to the full vector to wrap around.
    always_comb begin
        masked     = req & ({NREQ{1'b1}} << ptr);
        sel        = (|masked) ? masked : req;
        win_onehot = sel & (~sel + 1'b1);
        win_idx    = onehot_to_idx(win_onehot);
        any        = |req;
    end

endmodule

// File: rtl/rr_arbiter32.sv
// 32-way round-robin arbiter with registered one-hot grant and binary index; optional watchdog under ARB_TIMEOUT_EN.
// Latency: 1 cycle from req seen in IDLE to grant; release takes a 1-cycle bubble (3-cycle minimum grant spacing).
// Backpressure: owner holds grant until done or withdraws its req (or watchdog revokes it); other reqs wait.
module rr_arbiter32
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    // A counter too narrow for MAX_HOLD would never reach the limit.
    if (CNT_W < $clog2(MAX_HOLD + 1)) begin : g_cnt_w_check
        $error("rr_arbiter32: CNT_W too narrow for MAX_HOLD");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic             pick_any;
    logic [NREQ-1:0]  pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             release_req;
    logic             revoke;

    rr_pick32 u_pick (
        .req        (req),
        .ptr        (ptr),
        .any        (pick_any),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx)
    );

    // done and a withdrawn owner request collapse into one release.
    assign release_req = done | ~req[grant_idx];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;

    // Limit hits on the MAX_HOLD-th GRANT cycle (count starts at 0 on entry).
    assign revoke = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Hold counter runs only in GRANT; timeout pulses when the watchdog, not the owner, ends the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout  <= (state == GRANT) && revoke && !release_req;
            hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
        end
    end
`else
    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Arbitration FSM with registered grant outputs and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant       <= pick_onehot;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_req || revoke) begin
                        // Owner drops to lowest priority; 5-bit add wraps 31->0.
                        ptr         <= grant_idx + 1'b1;
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter32.sv
module tb_rr_arbiter32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic        done;
    logic [31:0] grant;
    logic [4:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    rr_arbiter32 #(.MAX_HOLD(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] req;
        logic        done;
        logic        vld;
        logic [4:0]  idx;
        logic        to;
    } vec_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] idx;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[23];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then pop and compare.
    task automatic step(input logic [31:0] r, input logic d, input logic v,
                        input logic [4:0] i, input logic t, input string tag);
        exp_t        e;
        logic [31:0] exp_g;
        req  = r;
        done = d;
        sb_q.push_back('{v, i, t});
        @(posedge clk);
        #1;
        e     = sb_q.pop_front();
        exp_g = e.vld ? (32'h1 << e.idx) : 32'h0;
        check({tag, ".grant"},       grant,              exp_g);
        check({tag, ".grant_idx"},   {27'b0, grant_idx}, e.vld ? {27'b0, e.idx} : 32'h0);
        check({tag, ".grant_valid"}, {31'b0, grant_valid}, {31'b0, e.vld});
        check({tag, ".timeout"},     {31'b0, timeout},   {31'b0, e.to});
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;

        //           req            done  vld   idx    to
        tbl[0]  = '{32'h0000_0010, 1'b0, 1'b1, 5'd4, 1'b0};   // first grant, 1-cycle latency
        tbl[1]  = '{32'h0000_0010, 1'b1, 1'b0, 5'd0, 1'b0};   // done -> release, ptr=5
        tbl[2]  = '{32'h0000_0011, 1'b0, 1'b0, 5'd0, 1'b0};   // bubble
        tbl[3]  = '{32'h0000_0011, 1'b0, 1'b1, 5'd0, 1'b0};   // wrap pick from ptr 5
        tbl[4]  = '{32'h0000_0011, 1'b1, 1'b0, 5'd0, 1'b0};   // release, ptr=1
        tbl[5]  = '{32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0};
        tbl[6]  = '{32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0};   // idle with no req
        tbl[7]  = '{32'h0000_0080, 1'b0, 1'b1, 5'd7, 1'b0};   // grant 7
        tbl[8]  = '{32'h0F00_0083, 1'b0, 1'b1, 5'd7, 1'b0};   // other bits toggle
        tbl[9]  = '{32'h0000_FF80, 1'b0, 1'b1, 5'd7, 1'b0};
        tbl[10] = '{32'h0000_FF00, 1'b0, 1'b0, 5'd0, 1'b0};   // req[7] withdrawn -> ptr=8
        tbl[11] = '{32'h0000_0140, 1'b0, 1'b0, 5'd0, 1'b0};
        tbl[12] = '{32'h0000_0140, 1'b0, 1'b1, 5'd8, 1'b0};   // proves ptr=8
        tbl[13] = '{32'h0000_0140, 1'b1, 1'b0, 5'd0, 1'b0};   // ptr=9
        tbl[14] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0, 1'b0};   // done in RELEASE ignored
        tbl[15] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0, 1'b0};   // done in IDLE ignored
        tbl[16] = '{32'h0000_0040, 1'b1, 1'b1, 5'd6, 1'b0};   // done in IDLE does not block grant
        tbl[17] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0, 1'b0};   // done + withdraw: single release, ptr=7
        tbl[18] = '{32'h0000_00C0, 1'b0, 1'b0, 5'd0, 1'b0};
        tbl[19] = '{32'h0000_00C0, 1'b0, 1'b1, 5'd7, 1'b0};   // ptr=7 picks 7 over 6
        tbl[20] = '{32'h0000_00C0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[21] = '{32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0};
        tbl[22] = '{32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset.grant",       grant,                32'h0);
        check("reset.grant_idx",   {27'b0, grant_idx},   32'h0);
        check("reset.grant_valid", {31'b0, grant_valid}, 32'h0);
        check("reset.timeout",     {31'b0, timeout},     32'h0);
        rst = 1'b0;

        for (int n = 0; n < 23; n++) begin
            step(tbl[n].req, tbl[n].done, tbl[n].vld, tbl[n].idx, tbl[n].to,
                 $sformatf("vec%0d", n));
        end

        // Full-load rotation from ptr=0: 0..31 then 0 again, 3 cycles per grant.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 33; k++) begin
            step(32'hFFFF_FFFF, 1'b1, 1'b1, 5'(k % 32), 1'b0, $sformatf("rr%0d.grant", k));
            step(32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 1'b0, $sformatf("rr%0d.rel", k));
            step(32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 1'b0, $sformatf("rr%0d.bub", k));
        end

        // Move ptr to 2, then reset in the middle of a grant on index 3.
        step(32'h0000_0002, 1'b0, 1'b1, 5'd1, 1'b0, "pre.g1");
        step(32'h0000_0002, 1'b1, 1'b0, 5'd0, 1'b0, "pre.r1");
        step(32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0, "pre.b1");
        step(32'h0000_0008, 1'b0, 1'b1, 5'd3, 1'b0, "pre.g3");
        #2;
        rst = 1'b1;
        #1;
        check("midrst.grant",       grant,                32'h0);
        check("midrst.grant_idx",   {27'b0, grant_idx},   32'h0);
        check("midrst.grant_valid", {31'b0, grant_valid}, 32'h0);
        check("midrst.timeout",     {31'b0, timeout},     32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(32'h0000_0006, 1'b0, 1'b1, 5'd1, 1'b0, "post.g1");
        step(32'h0000_0006, 1'b1, 1'b0, 5'd0, 1'b0, "post.r1");

`ifdef ARB_TIMEOUT_EN
        // Watchdog revoke after 4 GRANT cycles, then done exactly on the limit.
        step(32'h8000_0000, 1'b0, 1'b0, 5'd0,  1'b0, "to.bub");
        step(32'h8000_0000, 1'b0, 1'b1, 5'd31, 1'b0, "to.g1");
        step(32'h8000_0000, 1'b0, 1'b1, 5'd31, 1'b0, "to.g2");
        step(32'h8000_0000, 1'b0, 1'b1, 5'd31, 1'b0, "to.g3");
        step(32'h8000_0000, 1'b0, 1'b1, 5'd31, 1'b0, "to.g4");
        step(32'h8000_0000, 1'b0, 1'b0, 5'd0,  1'b1, "to.revoke");
        step(32'h8000_0000, 1'b0, 1'b0, 5'd0,  1'b0, "to.bub2");
        step(32'h8000_0000, 1'b0, 1'b1, 5'd31, 1'b0, "to.re1");
        step(32'h8000_0000, 1'b0, 1'b1, 5'd31, 1'b0, "to.re2");
        step(32'h8000_0000, 1'b0, 1'b1, 5'd31, 1'b0, "to.re3");
        step(32'h8000_0000, 1'b0, 1'b1, 5'd31, 1'b0, "to.re4");
        step(32'h8000_0000, 1'b1, 1'b0, 5'd0,  1'b0, "to.done_at_limit");
        step(32'h0000_0000, 1'b0, 1'b0, 5'd0,  1'b0, "to.quiet");
`endif

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
